grid_arbiter: RTL and testbench
===============================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter GRID_SIZE, default 32, SHALL set grid side in cells; GRID_SIZE is a power of two.
REQ-002 Parameter ADDR_W, default 10, SHALL equal 2*log2(GRID_SIZE); address = {row, col}.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vga_rd  in  1  VGA read strobe, one cell lookup.
REQ-006 vga_addr  in  ADDR_W  VGA cell address.
REQ-007 vga_rdata  out  1  VGA cell value.
REQ-008 vga_rvalid  out  1  vga_rdata valid.
REQ-009 game_req  in  1  game-logic access request, held until granted.
REQ-010 game_we  in  1  1 = write, 0 = read.
REQ-011 game_addr  in  ADDR_W  game cell address.
REQ-012 game_wdata  in  1  write value.
REQ-013 game_gnt  out  1  one-cycle grant pulse.
REQ-014 game_rdata  out  1  game read value.
REQ-015 game_rvalid  out  1  game_rdata valid.
REQ-016 clear_start  in  1  pulse to start a grid clear.
REQ-017 clear_busy  out  1  clear sequence in progress.
REQ-018 clear_done  out  1  one-cycle pulse when clear completes.

Function
REQ-019 Storage SHALL be a GRID_SIZE*GRID_SIZE x 1-bit array with exactly one access per clk cycle.
REQ-020 Priority per cycle SHALL be: vga_rd, then clear engine, then game_req.
REQ-021 A vga_rd SHALL always be served; vga_rdata/vga_rvalid SHALL appear exactly 1 cycle after vga_rd.
REQ-022 game_gnt SHALL assert in the cycle the game access is performed; game_req/addr/we/wdata SHALL be sampled in that cycle.
REQ-023 For a granted read, game_rdata and game_rvalid SHALL assert exactly 1 cycle after game_gnt.
REQ-024 A write SHALL be visible to any access issued in a later cycle.
REQ-025 The FSM SHALL have states IDLE and CLEAR: IDLE->CLEAR on clear_start; CLEAR->IDLE after the last cell is written.
REQ-026 CLEAR SHALL write every address 0..GRID_SIZE^2-1 in ascending order: 1 if row or col is 0 or GRID_SIZE-1, else 0.
REQ-027 A cycle taken by vga_rd SHALL stall the clear counter without skipping an address.
REQ-028 game_gnt SHALL stay 0 while clear_busy = 1.
REQ-029 clear_done SHALL pulse in the cycle after the final clear write; clear_busy SHALL drop in that same cycle.
REQ-030 clear_start during CLEAR SHALL restart the sweep at address 0 with no clear_done pulse.
REQ-031 If vga_rd and a game access target the same address in one cycle, VGA SHALL be served first and SHALL read the pre-write value.
REQ-032 With clear idle and vga_rd asserted at most every other cycle, game_req SHALL be granted within 2 cycles.

Reset
REQ-033 Reset SHALL force state IDLE, clear counter 0, and all outputs to 0.
REQ-034 Reset SHALL NOT initialise storage; array contents are undefined until a clear completes.
REQ-035 Reset mid-clear SHALL abort the sweep with no clear_done pulse.

Configuration
REQ-036 With GRID_ARB_STALL_CNT_EN defined, output stall_cnt (16 bits) SHALL count cycles with game_req=1 and game_gnt=0, saturating at 0xFFFF, and zero on reset.
REQ-037 Without GRID_ARB_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent.

Structure
REQ-038 GRID_SIZE, ADDR_W, the FSM state encoding and the border-test function SHALL live in shared package grid_pkg.
REQ-039 Storage SHALL be the sub-module grid_ram: single-port, synchronous read, 1-cycle latency. All arbitration and FSM logic SHALL stay in grid_arbiter.

Verification
REQ-040 After reset, pulse clear_start and hold vga_rd=0 -> clear_done exactly 1024 cycles later; reads of addr 0x000, 0x01F and 0x3E0 return 1; addr 0x021 returns 0.
REQ-041 During a clear, toggle vga_rd every other cycle -> every cell is still written; clear_done arrives after 1024 + number of VGA cycles.
REQ-042 Game write addr 0x210 = 1, then game read 0x210 -> game_gnt, then game_rvalid=1 with game_rdata=1 one cycle after that grant.
REQ-043 In the same cycle, vga_rd on 0x210 (cell=0) and game write 0x210 = 1 -> vga_rdata=0; game_gnt follows in the next cycle.
REQ-044 Assert game_req during a clear -> game_gnt stays 0 until after clear_done. With GRID_ARB_STALL_CNT_EN defined, stall_cnt equals the number of waited cycles.
REQ-045 Assert reset at cycle 500 of a clear -> clear_busy=0 next cycle, and no clear_done pulse occurs.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared constants for the grid arbiter: default geometry, FSM state encoding
// and the border-cell test used by the clear sweep.
package grid_pkg;

  localparam int GRID_SIZE = 32;
  localparam int ADDR_W    = 10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // A cell is on the border when its row or column touches the grid edge.
  function automatic logic is_border(input int unsigned row,
                                     input int unsigned col,
                                     input int unsigned grid);
    logic edge_s;
    if ((row == 32'd0) || (col == 32'd0) ||
        (row == grid - 32'd1) || (col == grid - 32'd1)) begin
      edge_s = 1'b1;
    end else begin
      edge_s = 1'b0;
    end
    return edge_s;
  endfunction

endpackage

// File: rtl/grid_arbiter_if.sv
// Bus bundle between the grid arbiter and its clients (VGA reader, game
// logic, clear control). The arbiter uses the slave modport.
interface grid_arbiter_if #(
  parameter int ADDR_W = grid_pkg::ADDR_W
) ();
  logic              vga_rd;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_rdata;
  logic              vga_rvalid;
  logic              game_req;
  logic              game_we;
  logic [ADDR_W-1:0] game_addr;
  logic              game_wdata;
  logic              game_gnt;
  logic              game_rdata;
  logic              game_rvalid;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;

  modport master (
    output vga_rd, vga_addr, game_req, game_we, game_addr, game_wdata, clear_start,
    input  vga_rdata, vga_rvalid, game_gnt, game_rdata, game_rvalid, clear_busy, clear_done
  );

  modport slave (
    input  vga_rd, vga_addr, game_req, game_we, game_addr, game_wdata, clear_start,
    output vga_rdata, vga_rvalid, game_gnt, game_rdata, game_rvalid, clear_busy, clear_done
  );
endinterface

// File: rtl/grid_ram.sv
// Single-port 1-bit grid storage with synchronous read (1-cycle latency).
// Contents are deliberately not reset; a clear sweep initialises them.
module grid_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wdata,
  output logic              rdata
);
  logic mem_r [DEPTH];

  // One access per cycle: optional write, registered read of the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end
endmodule

// File: rtl/grid_arbiter.sv
// Arbitrates the single-port grid RAM between VGA reads, the clear sweep and
// game-logic accesses (in that priority). Optional macro GRID_ARB_STALL_CNT_EN
// adds a saturating stall_cnt output counting game cycles spent waiting.
module grid_arbiter #(
  parameter int GRID_SIZE = grid_pkg::GRID_SIZE,
  parameter int ADDR_W    = grid_pkg::ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  grid_arbiter_if.slave  bus
`ifdef GRID_ARB_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);
  import grid_pkg::*;

  localparam int                COL_W     = $clog2(GRID_SIZE);
  localparam int                CELLS     = GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic              clr_req_s;
  logic              clr_we_s;
  logic              gnt_s;
  logic              ram_we_s;
  logic              ram_wdata_s;
  logic              ram_rdata_s;
  logic              done_nxt_s;
  logic              vga_rvalid_r;
  logic              game_rvalid_r;
  logic              clear_done_r;

  // Request arbitration; clear_start itself claims the cycle so the sweep
  // writes address 0 in the start cycle.
  always_comb begin
    clr_req_s  = 1'b0;
    clr_addr_s = {ADDR_W{1'b0}};
    clr_we_s   = 1'b0;
    gnt_s      = 1'b0;
    if (reset) begin
      clr_req_s = 1'b0;
    end else begin
      clr_req_s  = (state_r == ST_CLEAR) | bus.clear_start;
      clr_addr_s = bus.clear_start ? {ADDR_W{1'b0}} : cnt_r;
      clr_we_s   = clr_req_s & ~bus.vga_rd;
      gnt_s      = bus.game_req & ~bus.vga_rd & ~clr_req_s;
    end
  end

  // RAM port mux following the arbitration result.
  always_comb begin
    ram_addr_s  = bus.vga_addr;
    ram_we_s    = 1'b0;
    ram_wdata_s = 1'b0;
    if (bus.vga_rd) begin
      ram_addr_s = bus.vga_addr;
    end else if (clr_we_s) begin
      ram_addr_s  = clr_addr_s;
      ram_we_s    = 1'b1;
      ram_wdata_s = is_border(32'(clr_addr_s[ADDR_W-1:COL_W]),
                              32'(clr_addr_s[COL_W-1:0]),
                              32'(GRID_SIZE));
    end else if (gnt_s) begin
      ram_addr_s  = bus.game_addr;
      ram_we_s    = bus.game_we;
      ram_wdata_s = bus.game_wdata;
    end else begin
      ram_addr_s = bus.vga_addr;
    end
  end

  // Sweep FSM: a VGA-stolen cycle holds the current address instead of skipping it.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    if (clr_req_s) begin
      if (clr_we_s) begin
        if (clr_addr_s == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {ADDR_W{1'b0}};
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = clr_addr_s + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end else begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = clr_addr_s;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, counter and read-valid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {ADDR_W{1'b0}};
      vga_rvalid_r  <= 1'b0;
      game_rvalid_r <= 1'b0;
      clear_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      vga_rvalid_r  <= bus.vga_rd;
      game_rvalid_r <= gnt_s & ~bus.game_we;
      clear_done_r  <= done_nxt_s;
    end
  end

  grid_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign bus.vga_rvalid  = vga_rvalid_r;
  assign bus.vga_rdata   = vga_rvalid_r & ram_rdata_s;
  assign bus.game_rvalid = game_rvalid_r;
  assign bus.game_rdata  = game_rvalid_r & ram_rdata_s;
  assign bus.game_gnt    = gnt_s;
  assign bus.clear_busy  = (state_r == ST_CLEAR);
  assign bus.clear_done  = clear_done_r;

`ifdef GRID_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles where the game request waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (bus.game_req && !gnt_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_grid_arbiter.sv
// Directed, table-driven bench for grid_arbiter plus hand-written clear,
// collision, stall and reset-abort sequences.
module tb_grid_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  grid_arbiter_if #(.ADDR_W(10)) bus ();

`ifdef GRID_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  grid_arbiter #(.GRID_SIZE(32), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef GRID_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vga_rd;
    logic [9:0] vga_addr;
    logic       game_req;
    logic       game_we;
    logic [9:0] game_addr;
    logic       game_wdata;
    logic       exp_gnt;
    logic       exp_vv;
    logic       exp_vd;
    logic       exp_gv;
    logic       exp_gd;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.vga_rd      = 1'b0;
    bus.vga_addr    = 10'd0;
    bus.game_req    = 1'b0;
    bus.game_we     = 1'b0;
    bus.game_addr   = 10'd0;
    bus.game_wdata  = 1'b0;
    bus.clear_start = 1'b0;
  endtask

  task automatic vga_read(input logic [9:0] a, input logic exp, input string nm);
    bus.vga_rd   = 1'b1;
    bus.vga_addr = a;
    step();
    bus.vga_rd = 1'b0;
    chk({nm, " vld"}, 32'(bus.vga_rvalid), 32'd1);
    chk({nm, " dat"}, 32'(bus.vga_rdata), 32'(exp));
  endtask

  // Pulses clear_start and returns the cycle count until clear_done is seen.
  task automatic run_clear(output int n, output int early_done);
    n = 0;
    early_done = 0;
    bus.clear_start = 1'b1;
    do begin
      step();
      bus.clear_start = 1'b0;
      n++;
      if (bus.clear_done && n < 1024) early_done++;
    end while (!bus.clear_done && n < 3000);
  endtask

  initial begin
    int n, nv, w, early, seen_done, got, dones;
`ifdef GRID_ARB_STALL_CNT_EN
    logic [15:0] s0;
`endif
    n_checks = 0;
    n_fail   = 0;
    //              vga addr    req we gaddr  wd  gnt vv vd gv gd
    vecs[0]  = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 10'h01F, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 10'h3E0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 10'h021, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 10'h042, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 10'h05F, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h210, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h210, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h210, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 10'h210, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h3E1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset state
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk("rst vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    chk("rst game_rvalid", 32'(bus.game_rvalid), 32'd0);
    chk("rst clear_busy", 32'(bus.clear_busy), 32'd0);
    chk("rst clear_done", 32'(bus.clear_done), 32'd0);
`ifdef GRID_ARB_STALL_CNT_EN
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    reset = 1'b0;
    step();

    // Full clear with no VGA traffic
    run_clear(n, early);
    chk("clear latency", 32'(n), 32'd1024);
    chk("clear busy at done", 32'(bus.clear_busy), 32'd0);
    step();
    chk("clear done one pulse", 32'(bus.clear_done), 32'd0);

    // Table-driven single accesses
    for (int i = 0; i < 14; i++) begin
      bus.vga_rd     = vecs[i].vga_rd;
      bus.vga_addr   = vecs[i].vga_addr;
      bus.game_req   = vecs[i].game_req;
      bus.game_we    = vecs[i].game_we;
      bus.game_addr  = vecs[i].game_addr;
      bus.game_wdata = vecs[i].game_wdata;
      #1;
      chk($sformatf("vec%0d gnt", i), 32'(bus.game_gnt), 32'(vecs[i].exp_gnt));
      step();
      idle_inputs();
      chk($sformatf("vec%0d vga_rvalid", i), 32'(bus.vga_rvalid), 32'(vecs[i].exp_vv));
      chk($sformatf("vec%0d vga_rdata", i), 32'(bus.vga_rdata), 32'(vecs[i].exp_vd));
      chk($sformatf("vec%0d game_rvalid", i), 32'(bus.game_rvalid), 32'(vecs[i].exp_gv));
      chk($sformatf("vec%0d game_rdata", i), 32'(bus.game_rdata), 32'(vecs[i].exp_gd));
    end

    // Same-cycle VGA read and game write of one cell: VGA first, old value
    bus.vga_rd = 1'b1;  bus.vga_addr = 10'h211;
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 10'h211; bus.game_wdata = 1'b1;
    #1;
    chk("collide gnt0", 32'(bus.game_gnt), 32'd0);
    step();
    bus.vga_rd = 1'b0;
    #1;
    chk("collide vga_rdata", 32'(bus.vga_rdata), 32'd0);
    chk("collide gnt1", 32'(bus.game_gnt), 32'd1);
    step();
    idle_inputs();
    vga_read(10'h211, 1'b1, "collide after");

    // Clear with VGA stealing every other cycle
    nv = 0;
    n = 0;
    bus.clear_start = 1'b1;
    bus.vga_addr = 10'h021;
    do begin
      if (bus.vga_rd) nv++;
      step();
      bus.clear_start = 1'b0;
      n++;
      bus.vga_rd = ~bus.vga_rd;
    end while (!bus.clear_done && n < 3000);
    idle_inputs();
    chk("vga-clear latency", 32'(n), 32'(1024 + nv));
    vga_read(10'h000, 1'b1, "reclr 000");
    vga_read(10'h210, 1'b0, "reclr 210");
    vga_read(10'h211, 1'b0, "reclr 211");

    // Game request held during a clear
`ifdef GRID_ARB_STALL_CNT_EN
    s0 = stall_cnt;
`endif
    w = 0; got = 0; early = 0; seen_done = 0;
    bus.clear_start = 1'b1;
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 10'h3E0;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (bus.clear_done) seen_done = 1;
      if (bus.game_gnt) begin
        if (!seen_done || bus.clear_busy) early = 1;
        got = 1;
        break;
      end
      w++;
      step();
      bus.clear_start = 1'b0;
    end
    chk("stall granted", 32'(got), 32'd1);
    chk("stall no early gnt", 32'(early), 32'd0);
    chk("stall wait cycles", 32'(w), 32'd1024);
    step();
    idle_inputs();
    chk("stall rvalid", 32'(bus.game_rvalid), 32'd1);
    chk("stall rdata", 32'(bus.game_rdata), 32'd1);
`ifdef GRID_ARB_STALL_CNT_EN
    chk("stall_cnt delta", 32'(stall_cnt - s0), 32'(w));
`endif

    // Restart mid-sweep: sweep starts over, no done from the first run
    dones = 0;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.clear_done) dones++;
      step();
    end
    run_clear(n, early);
    chk("restart no done", 32'(dones + early), 32'd0);
    chk("restart latency", 32'(n), 32'd1024);

    // Reset at cycle 500 of a clear aborts it silently
    dones = 0;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    repeat (499) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort busy", 32'(bus.clear_busy), 32'd0);
    for (int i = 0; i < 1100; i++) begin
      if (bus.clear_done) dones++;
      step();
    end
    chk("abort no done", 32'(dones), 32'd0);
    chk("abort idle", 32'(bus.clear_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
